dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port round-robin arbiter sharing the single-port data memory between the CPU load/store stage (m0) and the boot/DMA loader (m1). It latches one winning request, performs exactly one memory access in the following cycle, and returns a one-cycle ack with registered read data and an error flag. It checks range and alignment before touching memory, so illegal accesses never reach the RAM.

## Interface
- RAM_SIZE, 256: memory size in bytes; legal byte addresses are 0..RAM_SIZE-1.
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- m0_req / m1_req  in  1  access request; held high until ack.
- m0_wr / m1_wr  in  1  1 = write, 0 = read; stable while req is high.
- m0_addr / m1_addr  in  32  byte address; stable while req is high.
- m0_wdata / m1_wdata  in  32  write data; stable while req is high.
- m0_ack / m1_ack  out  1  one-cycle completion pulse, registered.
- m0_err / m1_err  out  1  valid with ack; 1 = out-of-range or misaligned.
- m0_rdata / m1_rdata  out  32  registered read data; valid with ack; held until that port's next ack.
- mem_rd  out  1  memory read enable.
- mem_wr  out  1  memory write enable; the RAM commits on the rising edge at the end of the cycle.
- mem_addr  out  32  byte address to memory.
- mem_wdata  out  32  write data to memory.
- mem_rdata  in  32  combinational read data from memory.

## Operation
- FSM states: IDLE, ACCESS. Reset state is IDLE.
- Eligibility in IDLE: port k is eligible if mk_req=1 and mk_ack=0 in the current cycle. This prevents re-granting a request whose ack is being returned.
- IDLE, no eligible port: stay in IDLE.
- IDLE, one eligible port: grant it.
- IDLE, both eligible: grant the port that is not `last`.
- On grant: latch the port id, wr, addr and wdata into internal registers; set `last` to the granted port; go to ACCESS.
- Legality is computed from the latched request: legal = (addr < RAM_SIZE) && (addr[1:0] == 2'b00).
- ACCESS, combinational outputs:
  - mem_addr = latched addr; mem_wdata = latched wdata.
  - mem_rd = legal && !wr.
  - mem_wr = legal && wr && !reset.
- ACCESS, end of cycle:
  - Set the granted port's ack=1 and err=!legal.
  - Load that port's rdata with mem_rdata for a legal read, and with 0 otherwise (write or illegal access).
  - Return to IDLE.
- The other port's ack, err and rdata are unchanged.
- Outside ACCESS: mem_rd=0 and mem_wr=0. mem_addr and mem_wdata keep their last latched values.
- Reset values:
  - m0_ack, m1_ack, m0_err, m1_err = 0.
  - m0_rdata, m1_rdata = 0.
  - Latched addr, wdata, wr = 0, so mem_addr and mem_wdata read 0.
  - mem_rd, mem_wr = 0.
  - `last` = m1, so m0 wins the first tie.
- ack and err deassert in the cycle after they are asserted; both are single-cycle pulses.

## Timing
- Request sampled in cycle T (IDLE, eligible, won) → ACCESS in T+1 → ack, err and rdata valid in T+2. Read and write latency is 2 cycles.
- During an ack cycle (IDLE), the other port may be granted. Sustained throughput is one access per 2 cycles total.
- Under contention with both ports holding req, grants alternate strictly (m0, m1, m0, ...), so neither port is starved.
- A port holding req continuously after its ack is re-eligible in the cycle after the ack. Without contention its next grant is at T+3.
- A write commits at the rising edge ending ACCESS. A read by either port granted afterwards sees the new value.
- Reset asserted in any cycle:
  - Next state is IDLE and all outputs take their reset values.
  - If reset is asserted during ACCESS, mem_wr is forced to 0, so no write commits.
  - The in-flight request is dropped with no ack; the requester must reissue.
- A req deasserted before grant is simply not served. Deasserting after grant but before ack is illegal.

## Test plan
- Reset, then preload RAM word 0x10 = 0xCAFEF00D; m0 read addr 0x10 alone → m0_ack high exactly 2 cycles after req, m0_rdata=0xCAFEF00D, m0_err=0, one mem_rd pulse.
- m1 write 0x20 ← 0x12345678, then m0 read 0x20 → m1_ack then m0_ack, m0_rdata=0x12345678.
- m0 and m1 both assert read req in the same cycle and hold continuously → grants m0, m1, m0, m1 with acks 2 cycles apart; no port is served twice in a row.
- m0 read addr 0x100 (RAM_SIZE=256), and separately m1 write addr 0x22 → ack with err=1, rdata=0, mem_rd and mem_wr never asserted, RAM unchanged.
- m1 write 0x30 ← 0xDEADBEEF with reset asserted during the ACCESS cycle → no ack, mem_wr=0 at that edge, word 0x30 keeps its old value, all outputs 0 the next cycle.
- After any reset, m0 and m1 request simultaneously → m0 is granted first.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: bundle of the two requester ports and the data-memory port
// around the shared single-port data RAM.
//   m0_* : CPU load/store stage port (req/wr/addr/wdata in, ack/err/rdata out)
//   m1_* : boot/DMA loader port (same shape as m0)
//   mem_*: single-port RAM side (rd/wr/addr/wdata out, combinational rdata in)
// slave  modport: the arbiter's view.
// master modport: the surrounding system's view (requesters plus RAM).
interface dmem_arbiter_if;
  logic        m0_req;
  logic        m0_wr;
  logic [31:0] m0_addr;
  logic [31:0] m0_wdata;
  logic        m0_ack;
  logic        m0_err;
  logic [31:0] m0_rdata;

  logic        m1_req;
  logic        m1_wr;
  logic [31:0] m1_addr;
  logic [31:0] m1_wdata;
  logic        m1_ack;
  logic        m1_err;
  logic [31:0] m1_rdata;

  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  m0_req, m0_wr, m0_addr, m0_wdata,
    output m0_ack, m0_err, m0_rdata,
    input  m1_req, m1_wr, m1_addr, m1_wdata,
    output m1_ack, m1_err, m1_rdata,
    output mem_rd, mem_wr, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output m0_req, m0_wr, m0_addr, m0_wdata,
    input  m0_ack, m0_err, m0_rdata,
    output m1_req, m1_wr, m1_addr, m1_wdata,
    input  m1_ack, m1_err, m1_rdata,
    input  mem_rd, mem_wr, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port round-robin arbiter in front of the single-port data
// memory. One request is latched per grant, exactly one memory access is made
// in the following cycle, and the granted port receives a one-cycle ack with
// registered read data and an error flag. Out-of-range or misaligned accesses
// are flagged and never reach the RAM.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : dmem_arbiter_if.slave (m0/m1 request ports, memory port)
// Parameter:
//   RAM_SIZE : memory size in bytes; legal byte addresses 0..RAM_SIZE-1
module dmem_arbiter #(
  parameter int unsigned RAM_SIZE = 256
) (
  input logic           clk,
  input logic           reset,
  dmem_arbiter_if.slave bus
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t      state_q,    state_d;
  logic        last_q,     last_d;     // 0 = m0 served last, 1 = m1
  logic        gnt_q,      gnt_d;      // port owning the current access
  logic        wr_q,       wr_d;
  logic [31:0] addr_q,     addr_d;
  logic [31:0] wdata_q,    wdata_d;
  logic        m0_ack_q,   m0_ack_d;
  logic        m1_ack_q,   m1_ack_d;
  logic        m0_err_q,   m0_err_d;
  logic        m1_err_q,   m1_err_d;
  logic [31:0] m0_rdata_q, m0_rdata_d;
  logic [31:0] m1_rdata_q, m1_rdata_d;

  logic        elig0, elig1;
  logic        legal;
  logic        mem_rd, mem_wr;
  logic [31:0] rd_result;

  // A port whose ack is going out this cycle must not be granted again on
  // the same, still-high request.
  assign elig0 = bus.m0_req && !m0_ack_q;
  assign elig1 = bus.m1_req && !m1_ack_q;

  assign legal = (addr_q < 32'(RAM_SIZE)) && (addr_q[1:0] == 2'b00);

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    gnt_d      = gnt_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    m0_ack_d   = 1'b0;
    m1_ack_d   = 1'b0;
    m0_err_d   = 1'b0;
    m1_err_d   = 1'b0;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    rd_result  = 32'd0;

    unique case (state_q)
      IDLE: begin
        if (elig0 || elig1) begin
          // On a tie the port not served last wins.
          if (elig0 && elig1) gnt_d = ~last_q;
          else                gnt_d = elig1;
          last_d  = gnt_d;
          wr_d    = gnt_d ? bus.m1_wr    : bus.m0_wr;
          addr_d  = gnt_d ? bus.m1_addr  : bus.m0_addr;
          wdata_d = gnt_d ? bus.m1_wdata : bus.m0_wdata;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        mem_rd = legal && !wr_q;
        // Reset in this cycle must keep the RAM from committing the write.
        mem_wr = legal && wr_q && !reset;
        if (legal && !wr_q) rd_result = bus.mem_rdata;
        if (gnt_q) begin
          m1_ack_d   = 1'b1;
          m1_err_d   = !legal;
          m1_rdata_d = rd_result;
        end else begin
          m0_ack_d   = 1'b1;
          m0_err_d   = !legal;
          m0_rdata_d = rd_result;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      gnt_q      <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      m0_ack_q   <= 1'b0;
      m1_ack_q   <= 1'b0;
      m0_err_q   <= 1'b0;
      m1_err_q   <= 1'b0;
      m0_rdata_q <= 32'd0;
      m1_rdata_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      gnt_q      <= gnt_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      m0_ack_q   <= m0_ack_d;
      m1_ack_q   <= m1_ack_d;
      m0_err_q   <= m0_err_d;
      m1_err_q   <= m1_err_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
    end
  end

  assign bus.m0_ack    = m0_ack_q;
  assign bus.m1_ack    = m1_ack_q;
  assign bus.m0_err    = m0_err_q;
  assign bus.m1_err    = m1_err_q;
  assign bus.m0_rdata  = m0_rdata_q;
  assign bus.m1_rdata  = m1_rdata_q;
  assign bus.mem_rd    = mem_rd;
  assign bus.mem_wr    = mem_wr;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed self-checking bench for dmem_arbiter with a
// 64-word RAM model on the memory port.
module tb_dmem_arbiter;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   rd_cnt;
  int   wr_cnt;
  int   rd0;
  int   wr0;

  logic [31:0] ram [0:63];
  logic        pl_en;
  logic [5:0]  pl_idx;
  logic [31:0] pl_data;

  dmem_arbiter_if bus ();

  dmem_arbiter #(.RAM_SIZE(256)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.mem_rdata = ram[bus.mem_addr[7:2]];

  always @(posedge clk) begin
    if (pl_en)            ram[pl_idx] <= pl_data;
    else if (bus.mem_wr)  ram[bus.mem_addr[7:2]] <= bus.mem_wdata;
  end

  always @(negedge clk) begin
    if (bus.mem_rd) rd_cnt <= rd_cnt + 1;
    if (bus.mem_wr) wr_cnt <= wr_cnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  initial begin
    checks = 0; errors = 0; rd_cnt = 0; wr_cnt = 0;
    reset = 1'b1;
    pl_en = 1'b1; pl_idx = 6'd4; pl_data = 32'hCAFEF00D;
    bus.m0_req = 1'b0; bus.m0_wr = 1'b0; bus.m0_addr = 32'd0; bus.m0_wdata = 32'd0;
    bus.m1_req = 1'b0; bus.m1_wr = 1'b0; bus.m1_addr = 32'd0; bus.m1_wdata = 32'd0;
    step();
    pl_en = 1'b0;
    step();
    chk("rst_m0_ack",   {31'd0, bus.m0_ack}, 32'd0);
    chk("rst_m1_ack",   {31'd0, bus.m1_ack}, 32'd0);
    chk("rst_m0_err",   {31'd0, bus.m0_err}, 32'd0);
    chk("rst_m1_err",   {31'd0, bus.m1_err}, 32'd0);
    chk("rst_m0_rdata", bus.m0_rdata, 32'd0);
    chk("rst_m1_rdata", bus.m1_rdata, 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    chk("rst_mem_rd",   {31'd0, bus.mem_rd}, 32'd0);
    chk("rst_mem_wr",   {31'd0, bus.mem_wr}, 32'd0);
    reset = 1'b0;
    step();

    // m0 read 0x10 alone
    rd0 = rd_cnt;
    bus.m0_req = 1'b1; bus.m0_wr = 1'b0; bus.m0_addr = 32'h10;
    step();
    chk("t1_mem_rd",   {31'd0, bus.mem_rd}, 32'd1);
    chk("t1_mem_addr", bus.mem_addr, 32'h10);
    chk("t1_ack_early", {31'd0, bus.m0_ack}, 32'd0);
    step();
    chk("t1_ack",   {31'd0, bus.m0_ack}, 32'd1);
    chk("t1_err",   {31'd0, bus.m0_err}, 32'd0);
    chk("t1_rdata", bus.m0_rdata, 32'hCAFEF00D);
    bus.m0_req = 1'b0;
    step();
    chk("t1_ack_pulse",  {31'd0, bus.m0_ack}, 32'd0);
    chk("t1_rdata_held", bus.m0_rdata, 32'hCAFEF00D);
    chk("t1_rd_pulses",  32'(rd_cnt - rd0), 32'd1);

    // m1 write 0x20, then m0 read it back
    bus.m1_req = 1'b1; bus.m1_wr = 1'b1; bus.m1_addr = 32'h20; bus.m1_wdata = 32'h12345678;
    step();
    chk("t2_mem_wr",    {31'd0, bus.mem_wr}, 32'd1);
    chk("t2_mem_wdata", bus.mem_wdata, 32'h12345678);
    step();
    chk("t2_m1_ack",   {31'd0, bus.m1_ack}, 32'd1);
    chk("t2_m1_err",   {31'd0, bus.m1_err}, 32'd0);
    chk("t2_m1_rdata", bus.m1_rdata, 32'd0);
    chk("t2_ram",      ram[8], 32'h12345678);
    bus.m1_req = 1'b0;
    bus.m0_req = 1'b1; bus.m0_wr = 1'b0; bus.m0_addr = 32'h20;
    step();
    chk("t2_m0_mem_rd", {31'd0, bus.mem_rd}, 32'd1);
    step();
    chk("t2_m0_ack",   {31'd0, bus.m0_ack}, 32'd1);
    chk("t2_m0_rdata", bus.m0_rdata, 32'h12345678);
    bus.m0_req = 1'b0;
    step();

    // reset pulse, then contention: grants alternate starting with m0
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t3_rst_rdata", bus.m0_rdata, 32'd0);
    bus.m0_req = 1'b1; bus.m0_wr = 1'b0; bus.m0_addr = 32'h10;
    bus.m1_req = 1'b1; bus.m1_wr = 1'b0; bus.m1_addr = 32'h20;
    step();
    chk("t3_g1_addr", bus.mem_addr, 32'h10);
    step();
    chk("t3_a1_m0ack", {31'd0, bus.m0_ack}, 32'd1);
    chk("t3_a1_m1ack", {31'd0, bus.m1_ack}, 32'd0);
    chk("t3_a1_rdata", bus.m0_rdata, 32'hCAFEF00D);
    step();
    chk("t3_g2_addr", bus.mem_addr, 32'h20);
    chk("t3_g2_m0ack", {31'd0, bus.m0_ack}, 32'd0);
    step();
    chk("t3_a2_m1ack", {31'd0, bus.m1_ack}, 32'd1);
    chk("t3_a2_m0ack", {31'd0, bus.m0_ack}, 32'd0);
    chk("t3_a2_rdata", bus.m1_rdata, 32'h12345678);
    step();
    chk("t3_g3_addr", bus.mem_addr, 32'h10);
    step();
    chk("t3_a3_m0ack", {31'd0, bus.m0_ack}, 32'd1);
    chk("t3_a3_m1ack", {31'd0, bus.m1_ack}, 32'd0);
    step();
    chk("t3_g4_addr", bus.mem_addr, 32'h20);
    step();
    chk("t3_a4_m1ack", {31'd0, bus.m1_ack}, 32'd1);
    chk("t3_a4_m0ack", {31'd0, bus.m0_ack}, 32'd0);
    bus.m0_req = 1'b0; bus.m1_req = 1'b0;
    step();
    chk("t3_idle_rd", {31'd0, bus.mem_rd}, 32'd0);
    step();

    // illegal accesses: out of range read, misaligned write
    rd0 = rd_cnt; wr0 = wr_cnt;
    bus.m0_req = 1'b1; bus.m0_wr = 1'b0; bus.m0_addr = 32'h100;
    step();
    chk("t4_oor_mem_rd", {31'd0, bus.mem_rd}, 32'd0);
    step();
    chk("t4_oor_ack",   {31'd0, bus.m0_ack}, 32'd1);
    chk("t4_oor_err",   {31'd0, bus.m0_err}, 32'd1);
    chk("t4_oor_rdata", bus.m0_rdata, 32'd0);
    bus.m0_req = 1'b0;
    bus.m1_req = 1'b1; bus.m1_wr = 1'b1; bus.m1_addr = 32'h22; bus.m1_wdata = 32'hAAAA5555;
    step();
    chk("t4_mis_mem_wr", {31'd0, bus.mem_wr}, 32'd0);
    step();
    chk("t4_mis_ack",   {31'd0, bus.m1_ack}, 32'd1);
    chk("t4_mis_err",   {31'd0, bus.m1_err}, 32'd1);
    chk("t4_mis_rdata", bus.m1_rdata, 32'd0);
    bus.m1_req = 1'b0;
    step();
    chk("t4_err_pulse", {31'd0, bus.m1_err}, 32'd0);
    chk("t4_rd_cnt",    32'(rd_cnt - rd0), 32'd0);
    chk("t4_wr_cnt",    32'(wr_cnt - wr0), 32'd0);
    chk("t4_ram",       ram[8], 32'h12345678);

    // write aborted by reset during ACCESS
    pl_en = 1'b1; pl_idx = 6'd12; pl_data = 32'h11112222;
    step();
    pl_en = 1'b0;
    wr0 = wr_cnt;
    bus.m1_req = 1'b1; bus.m1_wr = 1'b1; bus.m1_addr = 32'h30; bus.m1_wdata = 32'hDEADBEEF;
    step();
    chk("t5_mem_wr_pre", {31'd0, bus.mem_wr}, 32'd1);
    reset = 1'b1;
    #1;
    chk("t5_mem_wr_rst", {31'd0, bus.mem_wr}, 32'd0);
    step();
    bus.m1_req = 1'b0;
    reset = 1'b0;
    chk("t5_m1_ack",    {31'd0, bus.m1_ack}, 32'd0);
    chk("t5_m1_err",    {31'd0, bus.m1_err}, 32'd0);
    chk("t5_ram",       ram[12], 32'h11112222);
    chk("t5_wr_cnt",    32'(wr_cnt - wr0), 32'd0);
    chk("t5_mem_addr",  bus.mem_addr, 32'd0);
    chk("t5_mem_wdata", bus.mem_wdata, 32'd0);
    chk("t5_mem_rd",    {31'd0, bus.mem_rd}, 32'd0);
    step();
    chk("t5_no_ack", {31'd0, bus.m1_ack}, 32'd0);

    // simultaneous requests after reset: m0 first
    bus.m0_req = 1'b1; bus.m0_wr = 1'b0; bus.m0_addr = 32'h30;
    bus.m1_req = 1'b1; bus.m1_wr = 1'b0; bus.m1_addr = 32'h10;
    step();
    chk("t6_g1_addr", bus.mem_addr, 32'h30);
    step();
    chk("t6_m0_ack",   {31'd0, bus.m0_ack}, 32'd1);
    chk("t6_m1_ack",   {31'd0, bus.m1_ack}, 32'd0);
    chk("t6_m0_rdata", bus.m0_rdata, 32'h11112222);
    bus.m0_req = 1'b0;
    step();
    chk("t6_g2_addr", bus.mem_addr, 32'h10);
    step();
    chk("t6_m1_ack2",  {31'd0, bus.m1_ack}, 32'd1);
    chk("t6_m1_rdata", bus.m1_rdata, 32'hCAFEF00D);
    bus.m1_req = 1'b0;
    step();
    chk("t6_m1_pulse", {31'd0, bus.m1_ack}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
